// File: rtl/run_controller.sv
// Run sequencer: owns the data-memory port while the core is held in Start,
// clears/preloads DM, runs the core with an Ack timeout and streams back a result window.
module run_controller #(
   parameter int DW       = 8,
   parameter int AW       = 8,
   parameter int CLEAR_EN = 1,
   parameter int RES_BASE = 5,
   parameter int RES_LEN  = 4,
   parameter int TIMEOUT  = 4096,
   parameter int CW       = 16
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Go,
   input  logic          LdValid,
   output logic          LdReady,
   input  logic [AW-1:0] LdAddr,
   input  logic [DW-1:0] LdData,
   input  logic          LdLast,
   output logic          DmWrEn,
   output logic [AW-1:0] DmAddr,
   output logic [DW-1:0] DmWrData,
   input  logic [DW-1:0] DmRdData,
   output logic          Start,
   input  logic          Ack,
   output logic          ResValid,
   output logic [DW-1:0] ResData,
   output logic [AW-1:0] ResIdx,
   output logic          ResLast,
   output logic          Busy,
   output logic          Done,
   output logic          TimedOut,
   output logic [CW-1:0] CycleCount
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_LOAD  = 3'd2,
      S_RUN   = 3'd3,
      S_READ  = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   localparam logic [AW-1:0] RES_BASE_W = AW'(RES_BASE);
   localparam logic [AW:0]   RES_LEN_W  = (AW+1)'(RES_LEN);
   localparam logic [CW:0]   TIMEOUT_W  = (CW+1)'(TIMEOUT);

   state_e        state_q, state_d;
   logic          start_q, start_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          tout_q, tout_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          wr_en_q, wr_en_d;
   logic [AW:0]   iss_q, iss_d;
   logic          res_valid_q, res_valid_d;
   logic          res_last_q, res_last_d;
   logic [DW-1:0] res_data_q, res_data_d;
   logic [AW-1:0] res_idx_q, res_idx_d;
   logic          load_beat_s;
   logic          launch_s;
   logic [CW:0]   inc_s;

   assign load_beat_s = (state_q == S_LOAD) & LdValid;

   // Next-state and registered-output logic for the sequencer
   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      busy_d      = busy_q;
      done_d      = done_q;
      tout_d      = tout_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wr_en_d     = wr_en_q;
      iss_d       = iss_q;
      res_valid_d = 1'b0;
      res_last_d  = 1'b0;
      res_data_d  = res_data_q;
      res_idx_d   = res_idx_q;
      launch_s    = 1'b0;
      inc_s       = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

      case (state_q)
         S_IDLE: begin
            launch_s = Go;
         end
         S_DONE: begin
            busy_d   = 1'b0;
            done_d   = 1'b1;
            launch_s = Go & ~busy_q;
         end
         S_CLEAR: begin
            addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
            if (addr_q == {AW{1'b1}}) begin
               state_d = S_LOAD;
               wr_en_d = 1'b0;
            end else begin
               wr_en_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (load_beat_s && LdLast) begin
               state_d = S_RUN;
               start_d = 1'b0;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = S_LOAD;
            end
         end
         S_RUN: begin
            if (Ack) begin
               state_d = S_READ;
               start_d = 1'b1;
               addr_d  = RES_BASE_W;
               iss_d   = {(AW+1){1'b0}};
            end else begin
               // Saturate rather than wrap so a huge TIMEOUT never aliases to a small count
               cnt_d = inc_s[CW] ? cnt_q : inc_s[CW-1:0];
               if (inc_s == TIMEOUT_W) begin
                  tout_d  = 1'b1;
                  start_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_READ: begin
            iss_d  = iss_q + {{AW{1'b0}}, 1'b1};
            addr_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
            // DmRdData in issue cycle j belongs to the address issued in cycle j-1
            if (iss_q != {(AW+1){1'b0}}) begin
               res_valid_d = 1'b1;
               res_data_d  = DmRdData;
               res_idx_d   = iss_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
               res_last_d  = (iss_q == RES_LEN_W);
            end else begin
               res_valid_d = 1'b0;
            end
            if (iss_q == RES_LEN_W) begin
               state_d = S_DONE;
            end else begin
               state_d = S_READ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (launch_s) begin
         done_d = 1'b0;
         tout_d = 1'b0;
         cnt_d  = {CW{1'b0}};
         busy_d = 1'b1;
         addr_d = {AW{1'b0}};
         if (CLEAR_EN != 0) begin
            state_d = S_CLEAR;
            wr_en_d = 1'b1;
         end else begin
            state_d = S_LOAD;
            wr_en_d = 1'b0;
         end
      end else begin
         launch_s = 1'b0;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tout_q      <= 1'b0;
         cnt_q       <= {CW{1'b0}};
         addr_q      <= {AW{1'b0}};
         wr_en_q     <= 1'b0;
         iss_q       <= {(AW+1){1'b0}};
         res_valid_q <= 1'b0;
         res_last_q  <= 1'b0;
         res_data_q  <= {DW{1'b0}};
         res_idx_q   <= {AW{1'b0}};
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         tout_q      <= tout_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wr_en_q     <= wr_en_d;
         iss_q       <= iss_d;
         res_valid_q <= res_valid_d;
         res_last_q  <= res_last_d;
         res_data_q  <= res_data_d;
         res_idx_q   <= res_idx_d;
      end
   end

   assign LdReady    = (state_q == S_LOAD);
   assign DmWrEn     = wr_en_q | load_beat_s;
   assign DmAddr     = load_beat_s ? LdAddr : addr_q;
   assign DmWrData   = load_beat_s ? LdData : {DW{1'b0}};
   assign Start      = start_q;
   assign ResValid   = res_valid_q;
   assign ResData    = res_data_q;
   assign ResIdx     = res_idx_q;
   assign ResLast    = res_last_q;
   assign Busy       = busy_q;
   assign Done       = done_q;
   assign TimedOut   = tout_q;
   assign CycleCount = cnt_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: instance A (clear enabled, base 5, timeout 64)
// and instance B (no clear, base 254) each with a synchronous-read DM model.
module tb_run_controller;

   logic       clk;
   logic       rst;
   int         n_cmp;
   int         n_err;

   logic       a_go, a_ld_valid, a_ld_ready, a_ld_last, a_wr_en, a_start, a_ack;
   logic [7:0] a_ld_addr, a_ld_data, a_addr, a_wr_data, a_rd_data;
   logic       a_res_valid, a_res_last, a_busy, a_done, a_tout;
   logic [7:0] a_res_data, a_res_idx;
   logic [15:0] a_cc;
   logic       core_we;
   logic [7:0] core_addr, core_wd;
   logic [7:0] mem_a [256];

   logic       b_go, b_ld_valid, b_ld_ready, b_ld_last, b_wr_en, b_start, b_ack;
   logic [7:0] b_ld_addr, b_ld_data, b_addr, b_wr_data, b_rd_data;
   logic       b_res_valid, b_res_last, b_busy, b_done, b_tout;
   logic [7:0] b_res_data, b_res_idx;
   logic [15:0] b_cc;
   logic [7:0] mem_b [256];

   run_controller #(.CLEAR_EN(1), .RES_BASE(5), .RES_LEN(4), .TIMEOUT(64)) u_dut_a (
      .Clk(clk), .Reset(rst), .Go(a_go), .LdValid(a_ld_valid), .LdReady(a_ld_ready),
      .LdAddr(a_ld_addr), .LdData(a_ld_data), .LdLast(a_ld_last), .DmWrEn(a_wr_en),
      .DmAddr(a_addr), .DmWrData(a_wr_data), .DmRdData(a_rd_data), .Start(a_start),
      .Ack(a_ack), .ResValid(a_res_valid), .ResData(a_res_data), .ResIdx(a_res_idx),
      .ResLast(a_res_last), .Busy(a_busy), .Done(a_done), .TimedOut(a_tout), .CycleCount(a_cc)
   );

   run_controller #(.CLEAR_EN(0), .RES_BASE(254), .RES_LEN(4), .TIMEOUT(64)) u_dut_b (
      .Clk(clk), .Reset(rst), .Go(b_go), .LdValid(b_ld_valid), .LdReady(b_ld_ready),
      .LdAddr(b_ld_addr), .LdData(b_ld_data), .LdLast(b_ld_last), .DmWrEn(b_wr_en),
      .DmAddr(b_addr), .DmWrData(b_wr_data), .DmRdData(b_rd_data), .Start(b_start),
      .Ack(b_ack), .ResValid(b_res_valid), .ResData(b_res_data), .ResIdx(b_res_idx),
      .ResLast(b_res_last), .Busy(b_busy), .Done(b_done), .TimedOut(b_tout), .CycleCount(b_cc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DM model A: synchronous read, controller port has priority over the core port
   always_ff @(posedge clk) begin
      if (a_wr_en) mem_a[a_addr] <= a_wr_data;
      else if (core_we) mem_a[core_addr] <= core_wd;
      a_rd_data <= mem_a[a_addr];
   end

   // DM model B
   always_ff @(posedge clk) begin
      if (b_wr_en) mem_b[b_addr] <= b_wr_data;
      b_rd_data <= mem_b[b_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_beat(input logic [7:0] addr, input logic [7:0] data, input logic last);
      a_ld_valid = 1'b1;
      a_ld_addr  = addr;
      a_ld_data  = data;
      a_ld_last  = last;
      #1;
      check("load_passthru_we", a_wr_en, 1);
      check("load_passthru_addr", a_addr, addr);
      check("load_passthru_data", a_wr_data, data);
      tick();
      a_ld_valid = 1'b0;
      a_ld_last  = 1'b0;
   endtask

   task automatic a_wait_load();
      for (int i = 0; i < 400; i++) begin
         if (a_ld_ready) break;
         tick();
      end
      check("wait_load", a_ld_ready, 1);
   endtask

   // Core model: writes results while running, raises Ack 'delay' cycles after Start falls
   task automatic a_core(input int delay, input logic writes, input logic go_mid);
      logic [31:0] cw;
      cw = 32'h44_33_22_11;
      check("start_low_in_run", a_start, 0);
      for (int i = 0; i < delay; i++) begin
         core_we = writes && (i < 4);
         if (i < 4) begin
            core_addr = 8'd5 + i[7:0];
            core_wd   = cw[8*i +: 8];
         end
         a_go = go_mid && (i == 10);
         tick();
         if (a_go) begin
            check("go_in_run_start", a_start, 0);
            check("go_in_run_busy", a_busy, 1);
         end
         a_go = 1'b0;
      end
      core_we = 1'b0;
      a_ack = 1'b1;
      tick();
      a_ack = 1'b0;
      check("cycle_count", a_cc, delay);
      check("start_high_after_ack", a_start, 1);
   endtask

   task automatic a_read_check(input logic [31:0] exp_w);
      check("rv_addr_cycle", a_res_valid, 0);
      check("read_first_addr", a_addr, 5);
      tick();
      check("rv_data_cycle", a_res_valid, 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         check("res_valid", a_res_valid, 1);
         check("res_data", a_res_data, exp_w[8*k +: 8]);
         check("res_idx", a_res_idx, k);
         check("res_last", a_res_last, k == 3);
         if (k == 3) check("done_after_last", a_done, 0);
         tick();
      end
      check("res_valid_end", a_res_valid, 0);
      check("done_set", a_done, 1);
      check("busy_clear", a_busy, 0);
      check("no_timeout", a_tout, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int bad;
      logic rv;
      logic [31:0] wa;
      logic [7:0] ev;
      n_cmp = 0; n_err = 0;
      rst = 1'b1;
      a_go = 1'b0; a_ld_valid = 1'b0; a_ld_addr = 8'd0; a_ld_data = 8'd0; a_ld_last = 1'b0; a_ack = 1'b0;
      b_go = 1'b0; b_ld_valid = 1'b0; b_ld_addr = 8'd0; b_ld_data = 8'd0; b_ld_last = 1'b0; b_ack = 1'b0;
      core_we = 1'b0; core_addr = 8'd0; core_wd = 8'd0;
      tick(); tick();
      check("rst_start", a_start, 1);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_tout", a_tout, 0);
      check("rst_ld_ready", a_ld_ready, 0);
      check("rst_wr_en", a_wr_en, 0);
      check("rst_res_valid", a_res_valid, 0);
      check("rst_res_last", a_res_last, 0);
      check("rst_cc", a_cc, 0);
      check("rst_addr", a_addr, 0);
      check("rst_res_idx", a_res_idx, 0);
      check("rst_res_data", a_res_data, 0);
      rst = 1'b0;

      // Pre-fill DM A with 0xFF through the core port
      for (int i = 0; i < 256; i++) begin
         core_we = 1'b1; core_addr = i[7:0]; core_wd = 8'hFF;
         tick();
      end
      core_we = 1'b0;

      // Clear run
      a_go = 1'b1; tick(); a_go = 1'b0;
      check("go_clear_wr", a_wr_en, 1);
      check("go_clear_addr", a_addr, 0);
      check("go_busy", a_busy, 1);
      n = 0; bad = 0;
      while (a_wr_en && !a_ld_ready && n < 400) begin
         if (a_addr !== n[7:0]) bad++;
         n++;
         tick();
      end
      check("clear_len", n, 256);
      check("clear_addr_seq", bad, 0);
      check("clear_then_ready", a_ld_ready, 1);
      check("start_in_load", a_start, 1);
      a_beat(8'd10, 8'h5A, 1'b1);
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (mem_a[i] !== ((i == 10) ? 8'h5A : 8'h00)) bad++;
      end
      check("clear_contents", bad, 0);
      check("clear_addr10", mem_a[10], 8'h5A);
      a_core(7, 1'b0, 1'b0);
      a_read_check(32'h0000_0000);

      // Timeout run
      a_go = 1'b1; tick(); a_go = 1'b0;
      a_wait_load();
      a_beat(8'd200, 8'h77, 1'b1);
      n = 0; rv = 1'b0;
      while (!a_start && n < 200) begin
         rv = rv | a_res_valid;
         n++;
         tick();
      end
      check("tout_run_cycles", n, 64);
      check("tout_flag", a_tout, 1);
      check("tout_cc", a_cc, 64);
      check("tout_done_next", a_done, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         rv = rv | a_res_valid;
      end
      check("tout_done", a_done, 1);
      check("tout_busy", a_busy, 0);
      check("tout_no_res", rv, 0);

      // Basic run restarted from DONE, with a Go pulse during RUN
      a_go = 1'b1; tick(); a_go = 1'b0;
      check("restart_done", a_done, 0);
      check("restart_tout", a_tout, 0);
      check("restart_cc", a_cc, 0);
      check("restart_busy", a_busy, 1);
      check("restart_clear", a_wr_en, 1);
      a_wait_load();
      for (int i = 0; i < 8; i++) a_beat(8'd128 + i[7:0], i[7:0], i == 7);
      bad = 0;
      for (int i = 0; i < 8; i++) if (mem_a[128 + i] !== i[7:0]) bad++;
      check("load_contents", bad, 0);
      a_core(20, 1'b1, 1'b1);
      a_read_check(32'h44_33_22_11);

      // Reset mid-LOAD, then a fresh run
      a_go = 1'b1; tick(); a_go = 1'b0;
      a_wait_load();
      a_beat(8'd20, 8'h99, 1'b0);
      check("still_loading", a_ld_ready, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("mid_rst_start", a_start, 1);
      check("mid_rst_ld_ready", a_ld_ready, 0);
      check("mid_rst_busy", a_busy, 0);
      check("mid_rst_wr_en", a_wr_en, 0);
      tick();
      check("mid_rst_idle", a_ld_ready, 0);
      a_go = 1'b1; tick(); a_go = 1'b0;
      a_wait_load();
      a_beat(8'd6, 8'h66, 1'b1);
      a_core(5, 1'b0, 1'b0);
      a_read_check(32'h00_00_66_00);

      // Instance B: no clear, result window wraps past the top of DM
      wa = 32'h01_00_FF_FE;
      b_go = 1'b1; tick(); b_go = 1'b0;
      check("b_go_ready", b_ld_ready, 1);
      check("b_go_no_clear", b_wr_en, 0);
      check("b_busy", b_busy, 1);
      for (int j = 0; j < 4; j++) begin
         b_ld_valid = 1'b1;
         b_ld_addr  = wa[8*j +: 8];
         b_ld_data  = 8'hA0 + j[7:0];
         b_ld_last  = (j == 3);
         tick();
      end
      b_ld_valid = 1'b0; b_ld_last = 1'b0;
      check("b_start_low", b_start, 0);
      tick(); tick(); tick();
      b_ack = 1'b1; tick(); b_ack = 1'b0;
      for (int j = 0; j < 6; j++) begin
         if (j < 4) check("wrap_addr", b_addr, wa[8*j +: 8]);
         if (j >= 2) begin
            ev = 8'hA0 + 8'(j - 2);
            check("wrap_valid", b_res_valid, 1);
            check("wrap_data", b_res_data, ev);
            check("wrap_idx", b_res_idx, j - 2);
            check("wrap_last", b_res_last, j == 5);
         end
         tick();
      end
      check("b_cc", b_cc, 3);
      check("b_done", b_done, 1);
      check("b_tout", b_tout, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
